// File: rtl/gray_stream_pkg.sv
// Shared definitions for the gray stream pairing block.
// Holds the pixel width and type, the default parameter values and a helper
// that sizes the inter-pair gap counter.
package gray_stream_pkg;

    localparam int PIX_W            = 8;
    localparam int DEF_DEPTH        = 16;
    localparam int DEF_GAP          = 2;
    localparam int DEF_FRAME_PIXELS = 4096;
    localparam int DEF_CNT_W        = 20;

    typedef logic [PIX_W-1:0] pixel_t;

    // Width needed to hold the value GAP; at least one bit so GAP=0 still
    // gives a legal counter.
    function automatic int gap_width(input int gap);
        int w;
        if (gap > 0) begin
            w = $clog2(gap + 1);
        end else begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/gray_sync_fifo.sv
// Synchronous FIFO for one gray pixel stream.
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   clear_i         synchronous flush (pointers back to zero)
//   wr_en_i/wr_data_i  write strobe and pixel
//   rd_en_i         pop the head entry (ignored when empty)
//   rd_data_o       current head entry (valid while !empty_o)
//   full_o/empty_o/count_o  occupancy, all derived from registered pointers
//   drop_o          a write was refused this cycle because the FIFO is full
// A write while full is still accepted when a pop happens in the same cycle.
module gray_sync_fifo
    import gray_stream_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_i,
    input  logic                     wr_en_i,
    input  logic [PIX_W-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [PIX_W-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     drop_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PIX_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    rd_ptr_d;
    logic [PW-1:0]    count_s;
    logic             full_s;
    logic             empty_s;
    logic             do_wr_s;
    logic             do_rd_s;

    // Pointers carry one extra wrap bit, so the difference is the occupancy
    // modulo 2*DEPTH and full/empty are unambiguous.
    assign count_s   = wr_ptr_q - rd_ptr_q;
    assign full_s    = (count_s == PW'(DEPTH));
    assign empty_s   = (count_s == {PW{1'b0}});
    assign count_o   = count_s;
    assign full_o    = full_s;
    assign empty_o   = empty_s;
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    // Accept/refuse decisions and next pointer values.
    always_comb begin
        do_wr_s  = 1'b0;
        do_rd_s  = 1'b0;
        drop_o   = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear_i) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
        end else begin
            do_rd_s = rd_en_i && !empty_s;
            // The slot freed by a same-cycle pop makes room for the write.
            do_wr_s = wr_en_i && (!full_s || do_rd_s);
            drop_o  = wr_en_i && full_s && !do_rd_s;
            if (do_wr_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_rd_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/gray_stream_pairer.sv
// Pairs two independent gray pixel streams for a downstream merger.
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   clear               synchronous flush of FIFOs, counters and sticky flags
//   enable              allows pair issue; writes are accepted regardless
//   gray_a_in/valid_a   stream A write port, full_a its FIFO full flag
//   gray_b_in/valid_b   stream B write port, full_b its FIFO full flag
//   gray1_out/gray2_out registered pair (A, B), held between pairs
//   data1_valid/data2_valid  identical one-cycle pair strobes
//   frame_done          pulses with the strobes on the last pair of a frame
//   pair_count          pairs issued so far in the current frame
//   overflow_a/overflow_b    sticky flags for dropped writes
module gray_stream_pairer
    import gray_stream_pkg::*;
#(
    parameter int DEPTH        = DEF_DEPTH,
    parameter int GAP          = DEF_GAP,
    parameter int FRAME_PIXELS = DEF_FRAME_PIXELS,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [7:0]       gray_a_in,
    input  logic             valid_a,
    input  logic [7:0]       gray_b_in,
    input  logic             valid_b,
    output logic             full_a,
    output logic             full_b,
    output logic [7:0]       gray1_out,
    output logic             data1_valid,
    output logic [7:0]       gray2_out,
    output logic             data2_valid,
    output logic             frame_done,
    output logic [CNT_W-1:0] pair_count,
    output logic             overflow_a,
    output logic             overflow_b
);

    localparam int GAP_W = gap_width(GAP);
    localparam int AW    = $clog2(DEPTH);

    logic [PIX_W-1:0] head_a_s;
    logic [PIX_W-1:0] head_b_s;
    logic             empty_a_s;
    logic             empty_b_s;
    logic [AW:0]      count_a_s;
    logic [AW:0]      count_b_s;
    logic             drop_a_s;
    logic             drop_b_s;
    logic             issue_s;
    logic             unused_count_s;

    logic [GAP_W-1:0] gap_q,        gap_d;
    logic [CNT_W-1:0] pair_count_q, pair_count_d;
    logic             valid_q,      valid_d;
    logic             frame_done_q, frame_done_d;
    logic [PIX_W-1:0] gray1_q,      gray1_d;
    logic [PIX_W-1:0] gray2_q,      gray2_d;
    logic             ovf_a_q,      ovf_a_d;
    logic             ovf_b_q,      ovf_b_d;

    gray_sync_fifo #(.DEPTH(DEPTH)) u_fifo_a (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (clear),
        .wr_en_i   (valid_a),
        .wr_data_i (gray_a_in),
        .rd_en_i   (issue_s),
        .rd_data_o (head_a_s),
        .full_o    (full_a),
        .empty_o   (empty_a_s),
        .count_o   (count_a_s),
        .drop_o    (drop_a_s)
    );

    gray_sync_fifo #(.DEPTH(DEPTH)) u_fifo_b (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (clear),
        .wr_en_i   (valid_b),
        .wr_data_i (gray_b_in),
        .rd_en_i   (issue_s),
        .rd_data_o (head_b_s),
        .full_o    (full_b),
        .empty_o   (empty_b_s),
        .count_o   (count_b_s),
        .drop_o    (drop_b_s)
    );

    // Occupancy counts are only needed for debug visibility in this block.
    assign unused_count_s = ^{count_a_s, count_b_s};

    // Both FIFOs always pop together, so a strobe is never unpaired.
    assign issue_s = enable && !empty_a_s && !empty_b_s &&
                     (gap_q == {GAP_W{1'b0}}) && !clear;

    // Next-state for pairing, spacing, frame counting and sticky flags.
    always_comb begin
        gap_d        = gap_q;
        pair_count_d = pair_count_q;
        valid_d      = 1'b0;
        frame_done_d = 1'b0;
        gray1_d      = gray1_q;
        gray2_d      = gray2_q;
        ovf_a_d      = ovf_a_q;
        ovf_b_d      = ovf_b_q;
        if (clear) begin
            gap_d        = {GAP_W{1'b0}};
            pair_count_d = {CNT_W{1'b0}};
            ovf_a_d      = 1'b0;
            ovf_b_d      = 1'b0;
        end else begin
            if (issue_s) begin
                gap_d   = GAP_W'(GAP);
                gray1_d = head_a_s;
                gray2_d = head_b_s;
                valid_d = 1'b1;
                // Last pair of the frame: flag it and restart the count.
                if (pair_count_q == CNT_W'(FRAME_PIXELS - 1)) begin
                    pair_count_d = {CNT_W{1'b0}};
                    frame_done_d = 1'b1;
                end else begin
                    pair_count_d = pair_count_q + CNT_W'(1);
                end
            end else if (gap_q != {GAP_W{1'b0}}) begin
                // Spacing keeps draining even while enable is low.
                gap_d = gap_q - GAP_W'(1);
            end else begin
                gap_d = gap_q;
            end
            ovf_a_d = ovf_a_q | drop_a_s;
            ovf_b_d = ovf_b_q | drop_b_s;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_q        <= {GAP_W{1'b0}};
            pair_count_q <= {CNT_W{1'b0}};
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
            gray1_q      <= {PIX_W{1'b0}};
            gray2_q      <= {PIX_W{1'b0}};
            ovf_a_q      <= 1'b0;
            ovf_b_q      <= 1'b0;
        end else begin
            gap_q        <= gap_d;
            pair_count_q <= pair_count_d;
            valid_q      <= valid_d;
            frame_done_q <= frame_done_d;
            gray1_q      <= gray1_d;
            gray2_q      <= gray2_d;
            ovf_a_q      <= ovf_a_d;
            ovf_b_q      <= ovf_b_d;
        end
    end

    assign gray1_out   = gray1_q;
    assign gray2_out   = gray2_q;
    assign data1_valid = valid_q;
    assign data2_valid = valid_q;
    assign frame_done  = frame_done_q;
    assign pair_count  = pair_count_q;
    assign overflow_a  = ovf_a_q;
    assign overflow_b  = ovf_b_q;

endmodule

// File: tb/tb_gray_stream_pairer.sv
// Directed bench for gray_stream_pairer. Two instances share all inputs:
// u_dut uses the default parameters (DEPTH=16, GAP=2), u_dut_f uses GAP=0
// and FRAME_PIXELS=4 for the frame wrap scenario.
module tb_gray_stream_pairer;

    logic        clk = 1'b0;
    logic        rst, clear, enable;
    logic [7:0]  gray_a_in, gray_b_in;
    logic        valid_a, valid_b;

    logic        fa_1, fb_1, d1v_1, d2v_1, fd_1, oa_1, ob_1;
    logic [7:0]  g1_1, g2_1;
    logic [19:0] pc_1;
    logic        fa_2, fb_2, d1v_2, d2v_2, fd_2, oa_2, ob_2;
    logic [7:0]  g1_2, g2_2;
    logic [19:0] pc_2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    gray_stream_pairer #(.DEPTH(16), .GAP(2), .FRAME_PIXELS(4096), .CNT_W(20)) u_dut (
        .clk(clk), .rst(rst), .clear(clear), .enable(enable),
        .gray_a_in(gray_a_in), .valid_a(valid_a), .gray_b_in(gray_b_in), .valid_b(valid_b),
        .full_a(fa_1), .full_b(fb_1), .gray1_out(g1_1), .data1_valid(d1v_1),
        .gray2_out(g2_1), .data2_valid(d2v_1), .frame_done(fd_1), .pair_count(pc_1),
        .overflow_a(oa_1), .overflow_b(ob_1)
    );

    gray_stream_pairer #(.DEPTH(16), .GAP(0), .FRAME_PIXELS(4), .CNT_W(20)) u_dut_f (
        .clk(clk), .rst(rst), .clear(clear), .enable(enable),
        .gray_a_in(gray_a_in), .valid_a(valid_a), .gray_b_in(gray_b_in), .valid_b(valid_b),
        .full_a(fa_2), .full_b(fb_2), .gray1_out(g1_2), .data1_valid(d1v_2),
        .gray2_out(g2_2), .data2_valid(d2v_2), .frame_done(fd_2), .pair_count(pc_2),
        .overflow_a(oa_2), .overflow_b(ob_2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; enable = 1'b0;
        valid_a = 1'b0; valid_b = 1'b0; gray_a_in = 8'd0; gray_b_in = 8'd0;
        #12;
        vectors++; if ({d1v_1, d2v_1, fd_1, fa_1, fb_1, oa_1, ob_1} !== 7'd0) begin miscompares++; $display("FAIL reset_flags: got %b want 0000000", {d1v_1, d2v_1, fd_1, fa_1, fb_1, oa_1, ob_1}); end
        vectors++; if (g1_1 !== 8'd0 || g2_1 !== 8'd0 || pc_1 !== 20'd0) begin miscompares++; $display("FAIL reset_data: got g1=%0d g2=%0d pc=%0d want 0 0 0", g1_1, g2_1, pc_1); end
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_aligned();
        do_clear();
        enable = 1'b1;
        gray_a_in = 8'd255; gray_b_in = 8'd64; valid_a = 1'b1; valid_b = 1'b1;
        step();
        valid_a = 1'b0; valid_b = 1'b0;
        vectors++; if (d1v_1 !== 1'b0) begin miscompares++; $display("FAIL aligned_early: got %b want 0", d1v_1); end
        step();
        vectors++; if (d1v_1 !== 1'b1 || d2v_1 !== 1'b1) begin miscompares++; $display("FAIL aligned_strobe: got %b%b want 11", d1v_1, d2v_1); end
        vectors++; if (g1_1 !== 8'd255 || g2_1 !== 8'd64) begin miscompares++; $display("FAIL aligned_data: got %0d,%0d want 255,64", g1_1, g2_1); end
        gray_a_in = 8'd7; gray_b_in = 8'd9; valid_a = 1'b1; valid_b = 1'b1;
        step();
        valid_a = 1'b0; valid_b = 1'b0;
        vectors++; if (d1v_1 !== 1'b0 || g1_1 !== 8'd255) begin miscompares++; $display("FAIL aligned_gap1: got v=%b g1=%0d want 0,255", d1v_1, g1_1); end
        step();
        vectors++; if (d1v_1 !== 1'b0) begin miscompares++; $display("FAIL aligned_gap2: got %b want 0", d1v_1); end
        step();
        vectors++; if (d1v_1 !== 1'b1 || g1_1 !== 8'd7 || g2_1 !== 8'd9) begin miscompares++; $display("FAIL aligned_second: got v=%b %0d,%0d want 1 7,9", d1v_1, g1_1, g2_1); end
    endtask

    task automatic test_skewed();
        logic exp_v;
        int k;
        do_clear();
        enable = 1'b1;
        for (int e = 0; e < 20; e++) begin
            valid_a = (e < 3);
            gray_a_in = 8'(10 * (e + 1));
            valid_b = (e >= 10 && e < 13);
            gray_b_in = 8'(e - 9);
            step();
            exp_v = (e == 11) || (e == 14) || (e == 17);
            vectors++; if (d1v_1 !== exp_v || d2v_1 !== exp_v) begin miscompares++; $display("FAIL skew_strobe e=%0d: got %b%b want %b", e, d1v_1, d2v_1, exp_v); end
            if (exp_v) begin
                k = (e - 11) / 3;
                vectors++; if (g1_1 !== 8'(10 * (k + 1)) || g2_1 !== 8'(k + 1)) begin miscompares++; $display("FAIL skew_data e=%0d: got %0d,%0d want %0d,%0d", e, g1_1, g2_1, 10 * (k + 1), k + 1); end
            end
        end
        valid_a = 1'b0; valid_b = 1'b0;
    endtask

    task automatic test_overflow();
        int pairs;
        do_clear();
        enable = 1'b0;
        for (int i = 0; i < 16; i++) begin
            valid_a = 1'b1; gray_a_in = 8'(i);
            step();
            if (i == 14) begin
                vectors++; if (fa_1 !== 1'b0) begin miscompares++; $display("FAIL ovf_full15: got %b want 0", fa_1); end
            end
        end
        vectors++; if (fa_1 !== 1'b1 || oa_1 !== 1'b0) begin miscompares++; $display("FAIL ovf_full16: got full=%b ovf=%b want 1,0", fa_1, oa_1); end
        gray_a_in = 8'd99;
        step();
        valid_a = 1'b0;
        vectors++; if (oa_1 !== 1'b1 || ob_1 !== 1'b0 || fa_1 !== 1'b1) begin miscompares++; $display("FAIL ovf_flag: got oa=%b ob=%b fa=%b want 1,0,1", oa_1, ob_1, fa_1); end
        enable = 1'b1;
        pairs = 0;
        for (int c = 0; c < 60; c++) begin
            valid_b = (c < 16);
            gray_b_in = 8'(100 + c);
            step();
            if (d1v_1 !== d2v_1) begin vectors++; miscompares++; $display("FAIL ovf_strobe_mismatch: got %b%b want equal", d1v_1, d2v_1); end
            if (d1v_1 === 1'b1) begin
                vectors++; if (g1_1 !== 8'(pairs) || g2_1 !== 8'(100 + pairs)) begin miscompares++; $display("FAIL ovf_pair%0d: got %0d,%0d want %0d,%0d", pairs, g1_1, g2_1, pairs, 100 + pairs); end
                pairs++;
            end
        end
        valid_b = 1'b0;
        vectors++; if (pairs !== 16) begin miscompares++; $display("FAIL ovf_pair_count: got %0d want 16", pairs); end
        vectors++; if (fa_1 !== 1'b0 || oa_1 !== 1'b1) begin miscompares++; $display("FAIL ovf_after: got fa=%b oa=%b want 0,1", fa_1, oa_1); end
    endtask

    task automatic test_frame_wrap();
        logic exp_fd;
        do_clear();
        enable = 1'b1;
        for (int e = 0; e < 11; e++) begin
            valid_a = (e < 9); valid_b = (e < 9);
            gray_a_in = 8'(e + 1); gray_b_in = 8'(e + 51);
            step();
            if (e >= 1 && e <= 9) begin
                exp_fd = (e == 4) || (e == 8);
                vectors++; if (d1v_2 !== 1'b1 || d2v_2 !== 1'b1 || g1_2 !== 8'(e)) begin miscompares++; $display("FAIL wrap_pair%0d: got v=%b%b g1=%0d want 11 %0d", e, d1v_2, d2v_2, g1_2, e); end
                vectors++; if (fd_2 !== exp_fd || pc_2 !== 20'(e % 4)) begin miscompares++; $display("FAIL wrap_cnt%0d: got fd=%b pc=%0d want %b %0d", e, fd_2, pc_2, exp_fd, e % 4); end
            end
        end
        valid_a = 1'b0; valid_b = 1'b0;
        vectors++; if (d1v_2 !== 1'b0 || fd_2 !== 1'b0 || pc_2 !== 20'd1) begin miscompares++; $display("FAIL wrap_end: got v=%b fd=%b pc=%0d want 0 0 1", d1v_2, fd_2, pc_2); end
    endtask

    task automatic test_full_read();
        int pairs;
        logic [7:0] exp_a;
        do_clear();
        vectors++; if (oa_1 !== 1'b0) begin miscompares++; $display("FAIL clear_ovf: got %b want 0", oa_1); end
        enable = 1'b0;
        for (int i = 0; i < 16; i++) begin
            valid_a = 1'b1; gray_a_in = 8'(i);
            step();
        end
        valid_a = 1'b0; valid_b = 1'b1; gray_b_in = 8'd200;
        step();
        valid_b = 1'b0;
        vectors++; if (fa_1 !== 1'b1 || d1v_1 !== 1'b0) begin miscompares++; $display("FAIL fr_setup: got fa=%b v=%b want 1,0", fa_1, d1v_1); end
        enable = 1'b1; valid_a = 1'b1; gray_a_in = 8'd77;
        step();
        valid_a = 1'b0;
        vectors++; if (d1v_1 !== 1'b1 || g1_1 !== 8'd0 || g2_1 !== 8'd200) begin miscompares++; $display("FAIL fr_issue: got v=%b %0d,%0d want 1 0,200", d1v_1, g1_1, g2_1); end
        vectors++; if (fa_1 !== 1'b1 || oa_1 !== 1'b0) begin miscompares++; $display("FAIL fr_accept: got fa=%b oa=%b want 1,0", fa_1, oa_1); end
        pairs = 0;
        for (int c = 0; c < 60; c++) begin
            valid_b = (c < 16); gray_b_in = 8'(c);
            step();
            if (d1v_1 === 1'b1) begin
                exp_a = (pairs < 15) ? 8'(pairs + 1) : 8'd77;
                vectors++; if (g1_1 !== exp_a || g2_1 !== 8'(pairs)) begin miscompares++; $display("FAIL fr_pair%0d: got %0d,%0d want %0d,%0d", pairs, g1_1, g2_1, exp_a, pairs); end
                pairs++;
            end
        end
        valid_b = 1'b0;
        vectors++; if (pairs !== 16 || oa_1 !== 1'b0) begin miscompares++; $display("FAIL fr_drain: got pairs=%0d oa=%b want 16,0", pairs, oa_1); end
    endtask

    task automatic test_clear_reset();
        do_clear();
        enable = 1'b1;
        for (int e = 0; e < 7; e++) begin
            valid_a = 1'b1; valid_b = (e < 2);
            gray_a_in = 8'(e + 1); gray_b_in = 8'(e + 1);
            step();
        end
        valid_a = 1'b0; valid_b = 1'b0;
        vectors++; if (pc_1 !== 20'd2) begin miscompares++; $display("FAIL cr_count: got %0d want 2", pc_1); end
        clear = 1'b1; valid_a = 1'b1; valid_b = 1'b1; gray_a_in = 8'd5; gray_b_in = 8'd5;
        step();
        clear = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
        vectors++; if (pc_1 !== 20'd0 || d1v_1 !== 1'b0 || fd_1 !== 1'b0 || fa_1 !== 1'b0) begin miscompares++; $display("FAIL cr_clear: got pc=%0d v=%b fd=%b fa=%b want 0 0 0 0", pc_1, d1v_1, fd_1, fa_1); end
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++; if (d1v_1 !== 1'b0) begin miscompares++; $display("FAIL cr_quiet%0d: got %b want 0", i, d1v_1); end
        end
        valid_a = 1'b1; valid_b = 1'b1; gray_a_in = 8'd33; gray_b_in = 8'd44;
        step();
        valid_b = 1'b0; gray_a_in = 8'd55;
        step();
        valid_a = 1'b0;
        vectors++; if (d1v_1 !== 1'b1 || g1_1 !== 8'd33 || pc_1 !== 20'd1) begin miscompares++; $display("FAIL cr_prerst: got v=%b g1=%0d pc=%0d want 1 33 1", d1v_1, g1_1, pc_1); end
        #2;
        rst = 1'b1;
        #1;
        vectors++; if (d1v_1 !== 1'b0 || g1_1 !== 8'd0 || g2_1 !== 8'd0 || pc_1 !== 20'd0) begin miscompares++; $display("FAIL cr_async: got v=%b g1=%0d g2=%0d pc=%0d want 0 0 0 0", d1v_1, g1_1, g2_1, pc_1); end
        @(negedge clk);
        rst = 1'b0;
        valid_b = 1'b1; gray_b_in = 8'd66;
        step();
        valid_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++; if (d1v_1 !== 1'b0) begin miscompares++; $display("FAIL cr_flushed%0d: got %b want 0", i, d1v_1); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_aligned();
        test_skewed();
        test_overflow();
        test_frame_wrap();
        test_full_read();
        test_clear_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gray_stream_pairer.md
Name: gray_stream_pairer

Overview:
Upstream feeder for gray_weighted_merger. It accepts two independent, unaligned 8-bit gray pixel streams (A and B), buffers each in its own FIFO, and issues them as aligned pairs. Each pair drives gray1/gray2 with simultaneous single-cycle data1_valid/data2_valid pulses. The block enforces a programmable minimum spacing between pairs, counts pairs per frame, and flags frame completion and overflow.

Parameters:
DEPTH, 16, per-stream FIFO depth in entries; power of 2, at least 2
GAP, 2, minimum idle cycles between issued pairs; 0 allows back-to-back issue
FRAME_PIXELS, 4096, pairs per frame; range 1..2^CNT_W-1
CNT_W, 20, width of the pair counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
clear  in  1  synchronous flush: FIFOs, counters and sticky flags
enable  in  1  when low, no pairs are issued; writes continue
gray_a_in  in  8  stream A pixel
valid_a  in  1  stream A write strobe
gray_b_in  in  8  stream B pixel
valid_b  in  1  stream B write strobe
full_a  out  1  FIFO A full
full_b  out  1  FIFO B full
gray1_out  out  8  paired pixel from A, to merger gray1_in
data1_valid  out  1  pair strobe, to merger data1_valid
gray2_out  out  8  paired pixel from B, to merger gray2_in
data2_valid  out  1  pair strobe, to merger data2_valid
frame_done  out  1  one-cycle pulse coincident with the last pair of a frame
pair_count  out  CNT_W  number of pairs issued in the current frame
overflow_a  out  1  sticky: a stream A write was dropped
overflow_b  out  1  sticky: a stream B write was dropped

Behaviour:
- Reset (rst high, asynchronous)
  - All outputs 0; FIFOs empty; gap counter 0; pair_count 0.
  - Reset mid-frame discards buffered data and any pending pair.
- Write
  - valid_x high and FIFO x not full: the data is stored at the edge.
  - valid_x high while full: the write is dropped and overflow_x is set.
  - Exception: if a read occurs in the same cycle, the write while full is accepted and no overflow is raised.
  - full_x is derived from the registered occupancy count.
- Issue condition, evaluated each cycle: enable && !empty_a && !empty_b && gap_cnt==0 && !clear.
  - When met, both FIFOs pop at the edge.
  - gray1_out/gray2_out register the head entries.
  - data1_valid and data2_valid are both 1 for exactly the following cycle.
  - When the condition is not met, both strobes are 0.
  - gray outputs hold their last value while the strobes are low.
- Latency: a pixel written at edge N can be issued at edge N+1 at the earliest. The strobe is visible in the cycle after edge N+1. FIFOs are not first-word-fall-through.
- Data strobes: data1_valid always equals data2_valid. The block never emits an unpaired strobe.
- Gap counter
  - On issue, the counter loads GAP.
  - It decrements by 1 per cycle while nonzero.
  - With GAP=0, pairs issue every cycle while both FIFOs are non-empty.
- Frame counter
  - pair_count increments on each issue.
  - On the issue that makes the count equal FRAME_PIXELS, frame_done pulses with the strobes and pair_count wraps to 0.
- enable low: issue is suppressed and the gap counter keeps counting down. Deasserting enable does not cancel an output already registered.
- clear (synchronous)
  - Empties both FIFOs; zeros pair_count, the gap counter, the strobes, frame_done and both overflow flags.
  - Has priority over simultaneous writes and issue.
- Wrap-around: FIFO pointers are log2(DEPTH)+1 bits and wrap naturally. Occupancy is computed modulo 2*DEPTH.

Decomposition:
- Shared package gray_stream_pkg holds PIX_W=8, the gray pixel type, and the default DEPTH/GAP/FRAME_PIXELS constants.
- Sub-module gray_sync_fifo (parameter DEPTH, 8-bit): a synchronous FIFO with full/empty/count outputs and an accepted simultaneous read+write when full. It is instantiated twice.
- Pairing, gap and frame logic live in the top module.

Test Plan:
- Aligned streams: write A=255,B=64 in the same cycle, with GAP=2. Expect data1_valid=data2_valid=1 one cycle after the write-edge+1, with gray1_out=255 and gray2_out=64. The next pair must be at least 3 cycles later.
- Skewed streams: write A=10,20,30 at cycles 0-2, then B=1,2,3 at cycles 10-12. Expect pairs (10,1),(20,2),(30,3) in order and no strobe before cycle 11.
- Overflow: with DEPTH=16 and enable=0, write 17 A pixels. Expect full_a=1 after 16 writes and the 17th dropped. overflow_a=1, overflow_b=0. After enable=1 with 16 B writes, exactly 16 pairs are issued.
- Frame wrap: with FRAME_PIXELS=4 and GAP=0, issue 9 pairs. Expect frame_done on pairs 4 and 8 only. pair_count reads 1 after pair 9.
- Full with simultaneous read: fill A to 16, keep B supplied, then write A on an issue cycle. The write is accepted, overflow_a stays 0, and occupancy stays 16.
- Clear/reset mid-frame: after 5 buffered pixels and pair_count=2, pulse clear. All counts and flags become 0 and no strobe follows. Repeat with asynchronous rst between edges; outputs must go to 0 immediately.
